// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the byte-wide memory arbiter.
// Holds the sequencer state enum, LSB size codes, the I/O window tag and a size decoder.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IC_RD   = 3'd1,
    LSB_RD  = 3'd2,
    LSB_WR  = 3'd3,
    IO_WAIT = 3'd4
  } state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // mem_a[17:16] value that selects the I/O window
  localparam logic [1:0] IO_HI = 2'b11;

  // Size code 3 is treated as a full word
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Request arbitration for the memory arbiter: picks IC or LSB while the sequencer is idle.
// Ports: clk, rst, rdy, idle, rollback, ic_req/lsb_req, ic_done/lsb_done in; grant_ic/grant_lsb out.
// MEM_ARB_RR_EN selects round-robin; otherwise LSB has fixed priority over IC.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic idle,
  input  logic rollback,
  input  logic ic_req,
  input  logic lsb_req,
  input  logic ic_done,
  input  logic lsb_done,
  output logic grant_ic,
  output logic grant_lsb
);

  logic ic_cand;
  logic lsb_cand;

  // A requester whose done is still visible is dropping its request
  assign ic_cand  = idle & ~rollback & ic_req  & ~ic_done;
  assign lsb_cand = idle & ~rollback & lsb_req & ~lsb_done;

`ifdef MEM_ARB_RR_EN
  logic last_ic_q;
  logic last_ic_d;

  // Last-grant bit follows each completed access
  always_comb begin
    last_ic_d = last_ic_q;
    if (ic_done) begin
      last_ic_d = 1'b1;
    end else if (lsb_done) begin
      last_ic_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_ic_q <= 1'b0;
    end else if (rdy) begin
      last_ic_q <= last_ic_d;
    end
  end

  always_comb begin
    grant_lsb = lsb_cand & (~ic_cand | last_ic_q);
    grant_ic  = ic_cand  & (~lsb_cand | ~last_ic_q);
  end
`else
  always_comb begin
    grant_lsb = lsb_cand;
    grant_ic  = ic_cand & ~lsb_cand;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Owner of the byte-wide RAM/IO port: serialises IC and LSB accesses into byte cycles.
// Ports: clk, rst, rdy; mem_din/mem_dout/mem_a/mem_wr; io_buffer_full; ic_* and lsb_* requester
// ports; rollback. Optional macro MEM_ARB_RR_EN enables round-robin arbitration.
module mem_arbiter #(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_HI  = mem_arb_pkg::IO_HI
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_done,
  output logic [31:0]       ic_data,
  input  logic              lsb_req,
  input  logic              lsb_we,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [1:0]        lsb_size,
  input  logic [31:0]       lsb_wdata,
  output logic              lsb_done,
  output logic [31:0]       lsb_rdata,
  input  logic              rollback
);

  import mem_arb_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        nb_q, nb_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [31:0]       buf_q, buf_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic              ic_done_q, ic_done_d;
  logic              lsb_done_q, lsb_done_d;
  logic [31:0]       ic_data_q, ic_data_d;
  logic [31:0]       lsb_rdata_q, lsb_rdata_d;

  logic              grant_ic;
  logic              grant_lsb;
  logic [2:0]        nxt;
  logic [1:0]        bi;
  logic [ADDR_W-1:0] wr_a;
  logic [7:0]        wr_b;
  logic              io_addr;
  logic              lsb_io;

  mem_arb_grant u_grant (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .idle      (state_q == IDLE),
    .rollback  (rollback),
    .ic_req    (ic_req),
    .lsb_req   (lsb_req),
    .ic_done   (ic_done_q),
    .lsb_done  (lsb_done_q),
    .grant_ic  (grant_ic),
    .grant_lsb (grant_lsb)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    nb_d        = nb_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = 1'b0;
    ic_done_d   = 1'b0;
    lsb_done_d  = 1'b0;
    ic_data_d   = ic_data_q;
    lsb_rdata_d = lsb_rdata_q;

    nxt     = cnt_q + 3'd1;
    // byte landing this edge was addressed two edges ago
    bi      = 2'(nxt - 3'd2);
    wr_a    = addr_q + ADDR_W'(cnt_q);
    wr_b    = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
    io_addr = (addr_q[17:16] == IO_HI);
    lsb_io  = (lsb_addr[17:16] == IO_HI);

    unique case (state_q)
      IDLE: begin
        mem_a_d = '0;
        if (grant_lsb) begin
          addr_d  = lsb_addr;
          nb_d    = size_bytes(lsb_size);
          wdata_d = lsb_wdata;
          buf_d   = '0;
          cnt_d   = '0;
          if (!lsb_we) begin
            state_d = LSB_RD;
            mem_a_d = lsb_addr;
          end else if (lsb_io && io_buffer_full) begin
            state_d = IO_WAIT;
          end else begin
            state_d    = LSB_WR;
            mem_a_d    = lsb_addr;
            mem_dout_d = lsb_wdata[7:0];
            mem_wr_d   = 1'b1;
            cnt_d      = 3'd1;
          end
        end else if (grant_ic) begin
          addr_d  = ic_addr;
          nb_d    = 3'd4;
          buf_d   = '0;
          cnt_d   = '0;
          state_d = IC_RD;
          mem_a_d = ic_addr;
        end
      end

      IC_RD, LSB_RD: begin
        if (rollback) begin
          state_d = IDLE;
          mem_a_d = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = nxt;
          // park on 0 once all bytes are issued so no I/O address repeats
          mem_a_d = (nxt < nb_q) ? addr_q + ADDR_W'(nxt) : '0;
          if (nxt >= 3'd2) begin
            buf_d[{bi, 3'b000} +: 8] = mem_din;
          end
          if (nxt == nb_q + 3'd1) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (state_q == IC_RD) begin
              ic_done_d = 1'b1;
              ic_data_d = buf_d;
            end else begin
              lsb_done_d  = 1'b1;
              lsb_rdata_d = buf_d;
            end
          end
        end
      end

      LSB_WR: begin
        if (cnt_q == nb_q) begin
          state_d    = IDLE;
          cnt_d      = '0;
          mem_a_d    = '0;
          lsb_done_d = 1'b1;
        end else if (io_addr && io_buffer_full) begin
          state_d = IO_WAIT;
          mem_a_d = '0;
        end else begin
          mem_a_d    = wr_a;
          mem_dout_d = wr_b;
          mem_wr_d   = 1'b1;
          cnt_d      = nxt;
        end
      end

      IO_WAIT: begin
        if (!io_buffer_full) begin
          state_d    = LSB_WR;
          mem_a_d    = wr_a;
          mem_dout_d = wr_b;
          mem_wr_d   = 1'b1;
          cnt_d      = nxt;
        end
      end

      default: begin
        state_d = IDLE;
        mem_a_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      nb_q        <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      buf_q       <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      ic_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
      ic_data_q   <= '0;
      lsb_rdata_q <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      nb_q        <= nb_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      ic_done_q   <= ic_done_d;
      lsb_done_q  <= lsb_done_d;
      ic_data_q   <= ic_data_d;
      lsb_rdata_q <= lsb_rdata_d;
    end
  end

  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign mem_wr    = mem_wr_q;
  assign ic_done   = ic_done_q;
  assign ic_data   = ic_data_q;
  assign lsb_done  = lsb_done_q;
  assign lsb_rdata = lsb_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// against a byte-array reference memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_done;
  logic [31:0] ic_data;
  logic        lsb_req;
  logic        lsb_we;
  logic [31:0] lsb_addr;
  logic [1:0]  lsb_size;
  logic [31:0] lsb_wdata;
  logic        lsb_done;
  logic [31:0] lsb_rdata;
  logic        rollback;

  int checks = 0;
  int errors = 0;
  int io_wr_cnt = 0;
  int io_rd_cnt = 0;

  logic [7:0] bus_mem [int unsigned];
  logic [7:0] ref_mem [int unsigned];

  mem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full),
    .ic_req         (ic_req),
    .ic_addr        (ic_addr),
    .ic_done        (ic_done),
    .ic_data        (ic_data),
    .lsb_req        (lsb_req),
    .lsb_we         (lsb_we),
    .lsb_addr       (lsb_addr),
    .lsb_size       (lsb_size),
    .lsb_wdata      (lsb_wdata),
    .lsb_done       (lsb_done),
    .lsb_rdata      (lsb_rdata),
    .rollback       (rollback)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] bus_rd(input logic [31:0] a);
    if (bus_mem.exists(a)) return bus_mem[a];
    return init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_byte(a);
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[8*k +: 8] = ref_rd(a + 32'(k));
    return r;
  endfunction

  // RAM/IO environment: registered read, stalls together with the core on rdy
  always @(posedge clk) begin
    if (rdy) begin
      mem_din <= bus_rd(mem_a);
      if (mem_wr) begin
        bus_mem[mem_a] = mem_dout;
        if (mem_a[17:16] == 2'b11) io_wr_cnt = io_wr_cnt + 1;
      end else if (mem_a[17:16] == 2'b11) begin
        io_rd_cnt = io_rd_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) check("done_excl", 32'(ic_done & lsb_done), 32'd0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_ic(input logic [31:0] addr);
    int e;
    logic [31:0] exp_d;
    exp_d = ref_load(addr, 4);
    ic_req = 1'b1;
    ic_addr = addr;
    e = 0;
    while (e < 40) begin
      tick();
      e++;
      if (e <= 4) begin
        check("ic_addr_seq", mem_a, addr + 32'(e - 1));
        check("ic_wr_low", 32'(mem_wr), 32'd0);
      end
      if (ic_done) break;
    end
    check("ic_lat", 32'(e), 32'd6);
    check("ic_data", ic_data, exp_d);
    ic_req = 1'b0;
    tick();
    check("ic_pulse", 32'(ic_done), 32'd0);
  endtask

  // rb_edge > 0 raises rollback for exactly that edge (counted from request)
  task automatic run_lsb(input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic [31:0] wdata,
                         input int rb_edge);
    int n;
    int e;
    int lat;
    logic [31:0] exp_d;
    n = nbytes(size);
    exp_d = ref_load(addr, n);
    lat = we ? n + 1 : n + 2;
    lsb_req = 1'b1;
    lsb_we = we;
    lsb_addr = addr;
    lsb_size = size;
    lsb_wdata = wdata;
    e = 0;
    while (e < 40) begin
      rollback = (rb_edge > 0) && (e + 1 == rb_edge);
      tick();
      e++;
      if (e <= n) begin
        check("lsb_addr_seq", mem_a, addr + 32'(e - 1));
        check("lsb_wr_flag", 32'(mem_wr), 32'(we));
        if (we) check("lsb_wr_data", 32'(mem_dout), 32'(wdata[8*(e-1) +: 8]));
      end
      if (lsb_done) break;
    end
    rollback = 1'b0;
    check("lsb_lat", 32'(e), 32'(lat));
    if (!we) check("lsb_rdata", lsb_rdata, exp_d);
    else for (int k = 0; k < n; k++) ref_mem[addr + 32'(k)] = wdata[8*k +: 8];
    lsb_req = 1'b0;
    tick();
    check("lsb_pulse", 32'(lsb_done), 32'd0);
  endtask

  initial begin
    int e;
    int le;
    int ie;
    int seen;
    int w0;
    int r0;
    logic [31:0] el;
    logic [31:0] ei;
    logic [31:0] a;

    rst = 1'b1;
    rdy = 1'b1;
    io_buffer_full = 1'b0;
    ic_req = 1'b0;
    ic_addr = '0;
    lsb_req = 1'b0;
    lsb_we = 1'b0;
    lsb_addr = '0;
    lsb_size = '0;
    lsb_wdata = '0;
    rollback = 1'b0;

    bus_mem[32'h10] = 8'h13; ref_mem[32'h10] = 8'h13;
    bus_mem[32'h11] = 8'h05; ref_mem[32'h11] = 8'h05;
    bus_mem[32'h12] = 8'h00; ref_mem[32'h12] = 8'h00;
    bus_mem[32'h13] = 8'h00; ref_mem[32'h13] = 8'h00;

    tick();
    tick();
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_dout", 32'(mem_dout), 32'd0);
    check("rst_ic_done", 32'(ic_done), 32'd0);
    check("rst_lsb_done", 32'(lsb_done), 32'd0);
    check("rst_ic_data", ic_data, 32'd0);
    check("rst_lsb_rdata", lsb_rdata, 32'd0);
    rst = 1'b0;
    tick();

    // first fetch from the preloaded word
    run_ic(32'h10);
    check("ic_first_word", ic_data, 32'h00000513);

    // simultaneous requests: LSB first, IC on the edge that ends lsb_done
    lsb_req = 1'b1; lsb_we = 1'b0; lsb_addr = 32'h100; lsb_size = 2'd0;
    ic_req = 1'b1; ic_addr = 32'h80;
    el = ref_load(32'h100, 1);
    ei = ref_load(32'h80, 4);
    le = 0; ie = 0; e = 0;
    while (e < 40 && ie == 0) begin
      tick();
      e++;
      if (le != 0 && e == le + 1) begin
        check("pri_lsb_pulse", 32'(lsb_done), 32'd0);
        lsb_req = 1'b0;
      end
      if (lsb_done && le == 0) begin
        le = e;
        check("pri_lsb_data", lsb_rdata, el);
      end
      if (ic_done) begin
        ie = e;
        check("pri_ic_data", ic_data, ei);
      end
    end
    ic_req = 1'b0;
    lsb_req = 1'b0;
    tick();
    check("pri_lsb_edge", 32'(le), 32'd3);
    check("pri_ic_edge", 32'(ie), 32'd9);

    // word store, then read it back
    run_lsb(1'b1, 32'h200, 2'd2, 32'hDEADBEEF, 0);
    run_lsb(1'b0, 32'h200, 2'd2, 32'h0, 0);
    check("st_readback", lsb_rdata, 32'hDEADBEEF);

    // I/O store held off by a full UART buffer
    io_buffer_full = 1'b1;
    w0 = io_wr_cnt;
    lsb_req = 1'b1; lsb_we = 1'b1; lsb_addr = 32'h00030000;
    lsb_size = 2'd0; lsb_wdata = 32'h41;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("io_hold_wr", 32'(mem_wr), 32'd0);
      check("io_hold_done", 32'(lsb_done), 32'd0);
    end
    io_buffer_full = 1'b0;
    tick();
    check("io_wr_a", mem_a, 32'h00030000);
    check("io_wr_d", 32'(mem_dout), 32'h41);
    check("io_wr_flag", 32'(mem_wr), 32'd1);
    tick();
    check("io_done", 32'(lsb_done), 32'd1);
    check("io_wr_off", 32'(mem_wr), 32'd0);
    lsb_req = 1'b0;
    ref_mem[32'h00030000] = 8'h41;
    tick();
    check("io_wr_once", 32'(io_wr_cnt - w0), 32'd1);

    // I/O halfword load touches each I/O byte address once
    r0 = io_rd_cnt;
    run_lsb(1'b0, 32'h00030010, 2'd1, 32'h0, 0);
    check("io_rd_once", 32'(io_rd_cnt - r0), 32'd2);

    // rollback two edges into a fetch aborts it
    ic_req = 1'b1; ic_addr = 32'h40;
    seen = 0;
    tick(); seen |= 32'(ic_done);
    tick(); seen |= 32'(ic_done);
    rollback = 1'b1;
    ic_req = 1'b0;
    tick();
    rollback = 1'b0;
    check("rb_mem_a", mem_a, 32'd0);
    check("rb_mem_wr", 32'(mem_wr), 32'd0);
    repeat (6) begin
      seen |= 32'(ic_done);
      tick();
    end
    check("rb_no_done", 32'(seen), 32'd0);
    run_ic(32'h44);

    // same rollback timing during a store: the store completes
    run_lsb(1'b1, 32'h240, 2'd2, 32'hCAFEF00D, 3);
    run_lsb(1'b0, 32'h240, 2'd3, 32'h0, 0);
    check("rb_st_data", lsb_rdata, 32'hCAFEF00D);

    // rdy low for two cycles mid-fetch
    ei = ref_load(32'h20, 4);
    ic_req = 1'b1; ic_addr = 32'h20;
    tick();
    tick();
    rdy = 1'b0;
    repeat (2) begin
      tick();
      check("frz_mem_a", mem_a, 32'h21);
      check("frz_mem_wr", 32'(mem_wr), 32'd0);
      check("frz_done", 32'(ic_done), 32'd0);
    end
    rdy = 1'b1;
    e = 4;
    while (e < 40 && !ic_done) begin
      tick();
      e++;
    end
    check("frz_lat", 32'(e), 32'd8);
    check("frz_data", ic_data, ei);
    ic_req = 1'b0;
    tick();

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      else a = 32'h1000 + 32'($urandom_range(0, 255));
      case ($urandom_range(0, 2))
        0: run_ic(a);
        1: run_lsb(1'b0, a, 2'($urandom_range(0, 3)), 32'h0, 0);
        default: run_lsb(1'b1, a, 2'($urandom_range(0, 3)), $urandom, 0);
      endcase
    end

    // asynchronous reset in the middle of a store
    lsb_req = 1'b1; lsb_we = 1'b1; lsb_addr = 32'h280;
    lsb_size = 2'd2; lsb_wdata = 32'h11223344;
    tick();
    tick();
    check("pre_rst_wr", 32'(mem_wr), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_mem_wr", 32'(mem_wr), 32'd0);
    check("arst_mem_a", mem_a, 32'd0);
    check("arst_mem_dout", 32'(mem_dout), 32'd0);
    check("arst_ic_done", 32'(ic_done), 32'd0);
    check("arst_lsb_done", 32'(lsb_done), 32'd0);
    lsb_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    run_ic(32'h10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sole owner of the byte-wide external RAM/IO port (mem_din/mem_dout/mem_a/mem_wr).
- Arbitrates between the instruction cache (4-byte reads) and the load/store buffer (1/2/4-byte reads and writes).
- Sequences each multi-byte access as back-to-back single-byte bus cycles, assembles read data little-endian, and pulses a per-requester done.
- Handles pipeline rollback and the UART full back-pressure.

Parameters:
- ADDR_W, 32, address width of requester ports and mem_a.
- IO_HI, 2'b11, value of mem_a[17:16] that marks an I/O address.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rdy  in  1  global ready; when low all state freezes
- mem_din  in  8  read data from RAM, valid the cycle after the address
- mem_dout  out  8  write data to RAM/IO
- mem_a  out  32  byte address
- mem_wr  out  1  1 = write, 0 = read
- io_buffer_full  in  1  UART TX buffer full
- ic_req  in  1  icache read request, held until ic_done
- ic_addr  in  32  icache word address
- ic_done  out  1  one-cycle pulse: ic_data valid
- ic_data  out  32  fetched instruction
- lsb_req  in  1  LSB request, held until lsb_done
- lsb_we  in  1  1 = store
- lsb_addr  in  32  start byte address
- lsb_size  in  2  0 = 1B, 1 = 2B, 2 = 4B, 3 = treated as 4B
- lsb_wdata  in  32  store data, byte 0 first
- lsb_done  out  1  one-cycle pulse: load data valid / store complete
- lsb_rdata  out  32  load data, zero-extended (sign extension is done in the LSB)
- rollback  in  1  speculative flush from the ROB

Behaviour:
- Reset (async): state = IDLE; mem_a = 0, mem_dout = 0, mem_wr = 0; ic_done = lsb_done = 0; ic_data = lsb_rdata = 0; counters cleared.
- rdy low: no register changes, outputs hold, no acceptance.
- All outputs are registered.
- States: IDLE, IC_RD, LSB_RD, LSB_WR, IO_WAIT.
- IDLE arbitration: default fixed priority, LSB over IC. A requester whose done is high this cycle is ignored, so a request is not re-accepted. Accept edge E0 latches addr, N bytes, and data.
- Read (IC_RD/LSB_RD):
  - Byte k address is driven after edge E0+k with mem_wr = 0.
  - mem_din for byte k is sampled at E0+k+2 into bits [8k+7:8k].
  - done is set at E0+N+1 with the final byte, so the data is visible in that cycle. A 4-byte read takes 5 edges.
  - Return to IDLE at the same edge. mem_a returns to 0 and mem_wr = 0.
- Write (LSB_WR): byte k drives mem_a = addr+k, mem_dout = wdata[8k+7:8k], mem_wr = 1 after E0+k. lsb_done is set at E0+N with mem_wr = 0, then the block returns to IDLE.
- IO write: if lsb_addr[17:16] == IO_HI and io_buffer_full is high at accept or before any byte, enter IO_WAIT with mem_wr = 0. Resume driving the byte at the first edge where io_buffer_full is low.
- IO reads are issued exactly once per byte; no speculative or repeated address is driven to an I/O address.
- rollback:
  - At any edge with rollback high, IC_RD and LSB_RD abort to IDLE, no done is raised, and partial data is discarded.
  - LSB_WR/IO_WAIT are committed stores and run to completion.
  - A request present in the same cycle as rollback is not accepted.
- Address arithmetic: addr+k is a 32-bit wrap-around add; no alignment is required.
- done pulses are exactly one cycle and never both high in the same cycle.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration. A last-grant bit toggles on each completed access. On simultaneous ic_req and lsb_req, the requester not granted last wins.
- Undefined: fixed LSB-over-IC priority. IC is served only when lsb_req is low.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum (IDLE, IC_RD, LSB_RD, LSB_WR, IO_WAIT)
  - size codes SZ_B/SZ_H/SZ_W
  - IO_HI constant
  - size-to-byte-count function
- One natural sub-module, mem_arb_grant: the combinational/registered grant logic including the RR_EN variant. The byte sequencer stays in mem_arbiter.

Test Plan:
- IC read 0x00000010, RAM bytes 13 05 00 00 -> ic_done exactly 5 edges after accept, ic_data = 0x00000513; mem_a sequence 0x10, 0x11, 0x12, 0x13; mem_wr stays 0.
- ic_req and lsb_req (load 1B at 0x100) in the same cycle, RR_EN undefined -> LSB served first, lsb_rdata = 0x000000XX; IC accepted on the cycle after lsb_done.
- Store 4B 0xDEADBEEF to 0x200 -> mem_wr = 1 for 4 cycles, mem_dout EF, BE, AD, DE at 0x200..0x203; lsb_done at E0+4.
- Store 1B 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr stays 0 while full, single write of 0x41 after release, then lsb_done.
- rollback asserted at E0+2 of an IC read -> no ic_done, state IDLE, next request accepted normally. The same rollback during a store -> store completes, lsb_done raised.
- rdy low for 2 cycles mid-read, then asserted async rst mid-write -> outputs frozen during rdy low; reset immediately gives mem_wr = 0, mem_a = 0, all done signals low.
